// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer states, writeSrc codes, opcodes and the
// instruction class the sequencer latches from the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    localparam logic [1:0] WSRC_ALU = 2'b11;
    localparam logic [1:0] WSRC_MEM = 2'b00;
    localparam logic [1:0] WSRC_IMM = 2'b01;
    localparam logic [1:0] WSRC_RES = 2'b10;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0001;
    localparam logic [3:0] OP_STORE  = 4'b0010;
    localparam logic [3:0] OP_JUMP   = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;
    localparam logic [3:0] OP_CP     = 4'b0111;
    localparam logic [3:0] OP_SHIFT  = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1011;

    typedef struct packed {
        logic halt;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic cpin;
    } instr_class_t;

    // Successor of EXEC, highest-priority class first.
    function automatic seq_state_t exec_next(input instr_class_t c);
        seq_state_t s;
        if (c.halt)
            s = S_HALT;
        else if (c.jump || c.branch)
            s = S_FETCH;
        else if (c.mem_read || c.mem_write)
            s = S_MEM;
        else
            s = S_WB;
        return s;
    endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Retired-instruction and busy-cycle counters; both wrap and clear only on reset.
module seq_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (retire)
                retired <= retired + CNT_W'(1);
            if (busy)
                cycles <= cycles + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the shared memory port.
// Performance counters are built only when SEQ_PERF_CNT_EN is defined.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             dec_halt,
    input  logic             dec_cpin,
    input  logic             dec_cpout,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_write,
    output logic             res_write,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    seq_state_t   state_reg;
    seq_state_t   state_next;
    instr_class_t cls_reg;

    logic mem_req_reg;
    logic mem_we_reg;
    logic mem_addr_sel_reg;
    logic reg_write_reg;
    logic res_write_reg;
    logic busy_reg;
    logic halted_reg;

    // cpout writes the register file through the ordinary reg_write path,
    // so the sequencer needs no distinct action for it.
    logic unused_cpout;
    assign unused_cpout = dec_cpout;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = exec_next(cls_reg);
            S_MEM:    if (mem_ready) state_next = cls_reg.mem_read ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with
    // state_reg and drop together with it on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            cls_reg          <= '0;
            mem_req_reg      <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_sel_reg <= 1'b0;
            reg_write_reg    <= 1'b0;
            res_write_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                cls_reg <= {dec_halt, dec_jump, dec_branch,
                            dec_mem_read, dec_mem_write, dec_cpin};
            mem_req_reg      <= (state_next == S_FETCH) || (state_next == S_MEM);
            mem_we_reg       <= (state_next == S_MEM) && cls_reg.mem_write;
            mem_addr_sel_reg <= (state_next == S_MEM);
            reg_write_reg    <= (state_next == S_WB) && !cls_reg.cpin;
            res_write_reg    <= (state_next == S_WB) && cls_reg.cpin;
            busy_reg         <= !(state_next inside {S_IDLE, S_HALT});
            halted_reg       <= (state_next == S_HALT);
        end
    end

    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr_sel = mem_addr_sel_reg;
    assign reg_write    = reg_write_reg;
    assign res_write    = res_write_reg;
    assign busy         = busy_reg;
    assign halted       = halted_reg;

    assign ir_load = (state_reg == S_FETCH) && mem_ready;
    assign pc_inc  = (state_reg == S_FETCH) && mem_ready;
    assign pc_load = (state_reg == S_EXEC) && !cls_reg.halt &&
                     (cls_reg.jump || (cls_reg.branch && br_taken));

`ifdef SEQ_PERF_CNT_EN
    logic retire_pulse;

    // Retire on EXEC->FETCH/HALT, on store completion in MEM, or on leaving WB.
    assign retire_pulse = ((state_reg == S_EXEC) &&
                           (cls_reg.halt || cls_reg.jump || cls_reg.branch)) ||
                          ((state_reg == S_MEM) && mem_ready && !cls_reg.mem_read) ||
                          (state_reg == S_WB);

    seq_perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk     (clk),
        .rst_n   (rst_n),
        .retire  (retire_pulse),
        .busy    (busy_reg),
        .retired (retired),
        .cycles  (cycles)
    );
`else
    assign retired = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer against a phase-list model.
module tb_instr_sequencer;

    localparam int CNT_W = 16;

    localparam int K_ALU    = 0;
    localparam int K_CPIN   = 1;
    localparam int K_CPOUT  = 2;
    localparam int K_LOAD   = 3;
    localparam int K_STORE  = 4;
    localparam int K_BRANCH = 5;
    localparam int K_JUMP   = 6;
    localparam int K_HALT   = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt, dec_cpin, dec_cpout;
    logic br_taken;
    logic mem_ready;
    logic mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load;
    logic reg_write, res_write, busy, halted;
    logic [CNT_W-1:0] retired, cycles;

    int compared   = 0;
    int mismatched = 0;
    logic [CNT_W-1:0] retired_m;
    logic [CNT_W-1:0] cycles_m;

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_branch    (dec_branch),
        .dec_jump      (dec_jump),
        .dec_halt      (dec_halt),
        .dec_cpin      (dec_cpin),
        .dec_cpout     (dec_cpout),
        .br_taken      (br_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_load       (ir_load),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .reg_write     (reg_write),
        .res_write     (res_write),
        .busy          (busy),
        .halted        (halted),
        .retired       (retired),
        .cycles        (cycles)
    );

    // Expected output vector {mem_req,mem_we,mem_addr_sel,ir_load,pc_inc,pc_load,
    // reg_write,res_write,busy,halted}; ir_load and pc_inc always coincide.
    function automatic logic [9:0] ev(input logic req, input logic we, input logic sel,
                                      input logic irl, input logic pcl, input logic regw,
                                      input logic resw, input logic bsy, input logic hlt);
        return {req, we, sel, irl, irl, pcl, regw, resw, bsy, hlt};
    endfunction

    function automatic logic [2*CNT_W-1:0] exp_cnt();
`ifdef SEQ_PERF_CNT_EN
        return {retired_m, cycles_m};
`else
        return '0;
`endif
    endfunction

    function automatic logic [9:0] obs_vec();
        return {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
                reg_write, res_write, busy, halted};
    endfunction

    // One clock cycle: drive inputs after the falling edge, check outputs 1 ns later.
    task automatic cyc(input logic st, input logic mr, input logic [6:0] dec, input logic bt,
                       input logic [9:0] expv, input logic ret, input string tag);
        logic [9:0] obs;
        logic [2*CNT_W-1:0] cnt_exp;
        @(negedge clk);
        start     = st;
        mem_ready = mr;
        {dec_halt, dec_jump, dec_branch, dec_mem_read, dec_mem_write, dec_cpin, dec_cpout} = dec;
        br_taken  = bt;
        #1;
        obs     = obs_vec();
        cnt_exp = exp_cnt();
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: outputs observed %b expected %b", tag, obs, expv);
        end
        compared++;
        assert ({retired, cycles} === cnt_exp) else begin
            mismatched++;
            $error("FAIL %s_cnt: retired/cycles observed %0d/%0d expected %0d/%0d",
                   tag, retired, cycles, cnt_exp[2*CNT_W-1:CNT_W], cnt_exp[CNT_W-1:0]);
        end
        cycles_m  = cycles_m + CNT_W'(expv[1]);
        retired_m = retired_m + CNT_W'(ret);
    endtask

    task automatic start_run();
        cyc(1'b1, 1'($urandom), 7'($urandom), 1'($urandom), ev(0,0,0,0,0,0,0,0,0), 1'b0, "idle_start");
    endtask

    // Expected behaviour is built as the list of phases the instruction passes
    // through: fetch (+waits), decode, exec, then mem (+waits) and/or writeback.
    task automatic run_instr(input int kind, input int fw, input int dw, input logic taken);
        logic [6:0] dec;
        logic [3:0] r;
        logic       is_mem, is_store, pcl, ends_exec;
        r = 4'($urandom);
        case (kind)
            K_ALU:    dec = 7'b0000000;
            K_CPIN:   dec = 7'b0000010;
            K_CPOUT:  dec = 7'b0000001;
            K_LOAD:   dec = 7'b0001000;
            K_STORE:  dec = 7'b0000100;
            K_BRANCH: dec = {3'b001, r[1:0], 2'b00};
            K_JUMP:   dec = {2'b01, r[2:0], 2'b00};
            default:  dec = {1'b1, r[3:0], 2'b00};
        endcase
        is_mem    = (kind == K_LOAD) || (kind == K_STORE);
        is_store  = (kind == K_STORE);
        ends_exec = (kind == K_BRANCH) || (kind == K_JUMP) || (kind == K_HALT);
        pcl       = (kind == K_JUMP) || ((kind == K_BRANCH) && taken);
        $display("instr kind=%0d dec=%b fetch_waits=%0d data_waits=%0d taken=%0d retired_model=%0d",
                 kind, dec, fw, dw, taken, retired_m);
        for (int i = 0; i <= fw; i++)
            cyc(1'b0, (i == fw), 7'($urandom), 1'($urandom),
                ev(1,0,0,(i == fw),0,0,0,1,0), 1'b0, "fetch");
        cyc(1'b0, 1'($urandom), dec, 1'($urandom), ev(0,0,0,0,0,0,0,1,0), 1'b0, "decode");
        cyc(1'b0, 1'($urandom), 7'($urandom), taken, ev(0,0,0,0,pcl,0,0,1,0), ends_exec, "exec");
        if (kind == K_HALT) begin
            for (int i = 0; i < 3; i++)
                cyc((i == 0) ? 1'b1 : 1'($urandom), 1'($urandom), 7'($urandom), 1'($urandom),
                    ev(0,0,0,0,0,0,0,0,1), 1'b0, "halt");
        end
        if (is_mem) begin
            for (int j = 0; j <= dw; j++)
                cyc(1'b0, (j == dw), 7'($urandom), 1'($urandom),
                    ev(1,is_store,1,0,0,0,0,1,0), is_store && (j == dw), "mem");
        end
        if (!ends_exec && !is_store)
            cyc(1'b0, 1'($urandom), 7'($urandom), 1'($urandom),
                ev(0,0,0,0,0,(kind != K_CPIN),(kind == K_CPIN),1,0), 1'b1, "wb");
    endtask

    initial begin
        logic [9:0] obs;
        rst_n = 1'b0;
        start = 1'b1;
        mem_ready = 1'b1;
        {dec_halt, dec_jump, dec_branch, dec_mem_read, dec_mem_write, dec_cpin, dec_cpout} = '0;
        br_taken  = 1'b0;
        retired_m = '0;
        cycles_m  = '0;

        // Reset held with start high: everything must stay zero.
        repeat (2) @(negedge clk);
        #1;
        obs = obs_vec();
        compared++;
        assert (obs === 10'b0) else begin
            mismatched++;
            $error("FAIL reset_outputs: observed %b expected %b", obs, 10'b0);
        end
        compared++;
        assert ({retired, cycles} === '0) else begin
            mismatched++;
            $error("FAIL reset_counters: observed %0d/%0d expected 0/0", retired, cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        cyc(1'b0, 1'b1, 7'($urandom), 1'b0, ev(0,0,0,0,0,0,0,0,0), 1'b0, "idle");
        cyc(1'b0, 1'b1, 7'($urandom), 1'b0, ev(0,0,0,0,0,0,0,0,0), 1'b0, "idle");

        start_run();
        run_instr(K_ALU,    0, 0, 1'b0);
        run_instr(K_LOAD,   2, 3, 1'b0);
        run_instr(K_STORE,  0, 0, 1'b0);
        run_instr(K_BRANCH, 0, 0, 1'b0);
        run_instr(K_BRANCH, 0, 0, 1'b1);
        run_instr(K_CPIN,   0, 0, 1'b0);
        run_instr(K_CPOUT,  0, 0, 1'b0);
        run_instr(K_JUMP,   1, 0, 1'b0);
        run_instr(K_STORE,  1, 2, 1'b0);
        for (int n = 0; n < 40; n++)
            run_instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom));
        run_instr(K_HALT, 0, 0, 1'b0);

        // Later run: reset in the middle of a stalled data access.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        retired_m = '0;
        cycles_m  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        cyc(1'b0, 1'b1, 7'($urandom), 1'b0, ev(1,0,0,1,0,0,0,1,0), 1'b0, "fetch2");
        cyc(1'b0, 1'b0, 7'b0001000, 1'b0, ev(0,0,0,0,0,0,0,1,0), 1'b0, "decode2");
        cyc(1'b0, 1'b0, 7'($urandom), 1'b0, ev(0,0,0,0,0,0,0,1,0), 1'b0, "exec2");
        cyc(1'b0, 1'b0, 7'($urandom), 1'b0, ev(1,0,1,0,0,0,0,1,0), 1'b0, "mem_stall");
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        obs = obs_vec();
        compared++;
        assert (obs === 10'b0) else begin
            mismatched++;
            $error("FAIL mid_mem_reset: observed %b expected %b", obs, 10'b0);
        end
        compared++;
        assert ({retired, cycles} === '0) else begin
            mismatched++;
            $error("FAIL mid_mem_reset_cnt: observed %0d/%0d expected 0/0", retired, cycles);
        end
        retired_m = '0;
        cycles_m  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 7'($urandom), 1'b0, ev(0,0,0,0,0,0,0,0,0), 1'b0, "idle_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
